// File: rtl/value_to_state_encoder.sv
// value_to_state_encoder
// Converts a 2048-style tile value (0 or 2^k) into its 4-bit tile state k.
// An accepted value is scanned one bit per cycle from the LSB. Scanning stops at
// the first set bit. The encoded state or an error flag is then held until the
// consumer takes it.
module value_to_state_encoder #(
    parameter int MAX_STATE = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_state,
    output logic        out_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] MAX_CNT = MAX_STATE[4:0];

    state_t      state;
    logic [15:0] shift_reg;
    // A nonzero value needs at most 15 shifts before bit 0 is set, so 5 bits never wrap.
    logic [4:0]  cnt;

    // Ready is decoded directly from the state, so a new value can only enter from IDLE.
    assign in_ready = (state == IDLE);

    // Handshake, scan and result registers in one clocked FSM, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: every register in this block uses non-blocking assignments.
        // This lets each branch read the pre-edge values of state, shift_reg and cnt
        // regardless of statement order.
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (in_value == 16'd0) begin
                            // Empty tile: the result is known immediately.
                            // out_valid is raised on the next edge, from DONE.
                            state     <= DONE;
                            out_state <= 4'd0;
                            out_error <= 1'b0;
                        end else begin
                            shift_reg <= in_value;
                            cnt       <= 5'd0;
                            state     <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    if (shift_reg[0]) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        // Legal only if this was the sole set bit and k is in 1..MAX_STATE.
                        if (shift_reg == 16'd1 && cnt != 5'd0 && cnt <= MAX_CNT) begin
                            out_state <= cnt[3:0];
                            out_error <= 1'b0;
                        end else begin
                            out_state <= 4'd0;
                            out_error <= 1'b1;
                        end
                    end else begin
                        shift_reg <= shift_reg >> 1;
                        cnt       <= cnt + 5'd1;
                    end
                end

                DONE: begin
                    // A zero-value result arrives here with out_valid still low.
                    // out_ready only counts once the result is actually presented.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_value_to_state_encoder.sv
// Directed bench for value_to_state_encoder.
// Each value is accepted, the latency to out_valid is measured in clock edges,
// and the result is compared with hand-computed expectations.
module tb_value_to_state_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_state;
    logic        out_error;

    int total = 0;
    int bad   = 0;
    logic hold_ready = 1'b0;

    value_to_state_encoder #(.MAX_STATE(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_error (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a value for exactly one edge. The caller must ensure in_ready is high.
    task automatic accept(input logic [15:0] v);
        in_valid = 1'b1;
        in_value = v;
        step();
        in_valid = 1'b0;
        in_value = 16'hDEAD;
    endtask

    // Count edges after the accept edge until out_valid is seen, with a 40-edge bound.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Run one full transaction: accept, measure latency, check result, release, check idle.
    task automatic run(input string tag, input logic [15:0] v, input int exp_lat,
                       input logic [3:0] exp_state, input logic exp_err);
        int lat;
        check({tag, ".ready_before"}, in_ready, 1);
        accept(v);
        wait_valid(lat);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".state"}, out_state, exp_state);
        check({tag, ".error"}, out_error, exp_err);
        out_ready = 1'b1;
        step();
        out_ready = hold_ready;
        check({tag, ".valid_cleared"}, out_valid, 0);
        check({tag, ".ready_after"}, in_ready, 1);
    endtask

    initial begin
        int ones;
        int lat;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_value  = 16'h0000;
        out_ready = 1'b0;
        step();
        step();
        check("reset.out_valid", out_valid, 0);
        check("reset.out_state", out_state, 0);
        check("reset.out_error", out_error, 0);
        check("reset.in_ready", in_ready, 1);
        rst = 1'b1;
        step();

        // Basic encodings, error cases and early exit on non-powers of two.
        run("v0008", 16'h0008, 4, 4'd3, 1'b0);
        run("v0000", 16'h0000, 1, 4'd0, 1'b0);
        run("v000C", 16'h000C, 3, 4'd0, 1'b1);
        run("v0001", 16'h0001, 1, 4'd0, 1'b1);
        run("v8000", 16'h8000, 16, 4'd0, 1'b1);
        run("v0003", 16'h0003, 1, 4'd0, 1'b1);
        run("v0006", 16'h0006, 2, 4'd0, 1'b1);
        run("vFFF0", 16'hFFF0, 5, 4'd0, 1'b1);

        // Back-pressure: the result holds for 5 cycles and a new value is refused.
        accept(16'h4000);
        wait_valid(lat);
        check("hold.latency", lat, 15);
        in_valid = 1'b1;
        in_value = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold.valid", out_valid, 1);
            check("hold.state", out_state, 14);
            check("hold.error", out_error, 0);
            check("hold.in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold.released", out_valid, 0);
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid === 1'b1) ones++;
        end
        check("hold.no_phantom", ones, 0);
        check("hold.idle_ready", in_ready, 1);

        // Reset during a scan aborts it. A value offered during reset is ignored.
        accept(16'h0400);
        step();
        step();
        check("abort.scanning", in_ready, 0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_value = 16'h0000;
        step();
        check("abort.valid_in_reset", out_valid, 0);
        check("abort.ready_in_reset", in_ready, 1);
        rst      = 1'b0;
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        check("abort.ready_after_release", in_ready, 1);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (out_valid === 1'b1) ones++;
        end
        check("abort.no_result", ones, 0);
        run("after_abort", 16'h0002, 2, 4'd1, 1'b0);

        // Sweep of every legal power of two with out_ready held high throughout.
        hold_ready = 1'b1;
        out_ready  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            logic [15:0] v;
            v = 16'd1 << k;
            run($sformatf("sweep%0d", k), v, k + 1, 4'(k), 1'b0);
        end
        hold_ready = 1'b0;
        out_ready  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/value_to_state_encoder.md
VALUE_TO_STATE_ENCODER -- requirements
Module: value_to_state_encoder

Interface
REQ-001 SHALL have parameter MAX_STATE, default 14: highest legal tile state; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: in_value presented.
REQ-005 SHALL have port in_ready, output, 1: block can accept a value.
REQ-006 SHALL have port in_value, input, 16: tile value (0 = empty tile, else 2^k).
REQ-007 SHALL have port out_valid, output, 1: out_state/out_error valid.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-009 SHALL have port out_state, output, 4: encoded tile state, k for value 2^k.
REQ-010 SHALL have port out_error, output, 1: in_value not encodable.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-012 SHALL drive in_ready = 1 only in IDLE, decoded from state.
REQ-013 SHALL accept input on an edge where in_valid && in_ready; values presented outside this condition are ignored.
REQ-014 On accept with in_value == 0, SHALL go directly to DONE with out_state = 0 and out_error = 0, so out_valid rises 1 cycle after the accept edge.
REQ-015 On accept with nonzero in_value, SHALL load a 16-bit shift register with in_value, clear a 5-bit counter, and go to SCAN.
REQ-016 In SCAN with shift register bit 0 = 0, SHALL shift the register right by 1 and increment the counter, one bit per cycle.
REQ-017 In SCAN with shift register bit 0 = 1, SHALL go to DONE.
  - If register == 1 and counter is in 1..MAX_STATE: out_state = counter[3:0], out_error = 0.
  - Otherwise: out_state = 0, out_error = 1.
REQ-018 Latency: for value 2^k, out_valid SHALL rise exactly k+1 cycles after the accept edge.
REQ-019 Any value with bit 0 set SHALL finish after 1 SCAN cycle. This includes value 1 (k = 0, illegal) and every odd value, all reported as error.
REQ-020 Non-power-of-two values SHALL be flagged at the first set bit (early exit), not after a full scan.
REQ-021 Values above 2^MAX_STATE that are powers of two (e.g. 16'h8000 with MAX_STATE = 14) SHALL report out_error = 1 and out_state = 0.
REQ-022 In DONE, SHALL hold out_valid = 1 with out_state and out_error stable until out_ready = 1.
REQ-023 On the DONE edge with out_ready = 1, SHALL return to IDLE and clear out_valid. The next accept can occur no earlier than the following edge (no same-cycle back-to-back).
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 out_state and out_error SHALL be registered outputs, with no combinational path from in_value.
REQ-026 The counter SHALL never wrap: at most 15 shifts are possible before bit 0 is set, since the value is nonzero.

Reset
REQ-027 While rst = 0 at an edge, SHALL force: state IDLE, out_valid 0, out_state 0, out_error 0, shift register 0, counter 0.
REQ-028 Reset during SCAN or DONE SHALL abort the operation. No result is produced for the aborted value, and in_ready = 1 on the first cycle after reset release.
REQ-029 Reset SHALL take priority over every handshake on the same edge.

Verification
REQ-030 Accept in_value 16'h0008, out_ready = 1 -> out_valid at accept+4, out_state 3, out_error 0, then in_ready back to 1 the next cycle.
REQ-031 Accept 16'h0000 -> out_valid at accept+1, out_state 0, out_error 0.
REQ-032 Accept 16'h000C, 16'h0001, then 16'h8000 -> each gives out_error 1 and out_state 0:
  - 16'h000C: valid at accept+3.
  - 16'h0001: valid at accept+1.
  - 16'h8000: valid at accept+16.
REQ-033 Accept 16'h4000 with out_ready held 0 for 5 cycles after out_valid -> out_state 14 and out_error 0 held stable throughout; in_ready stays 0 and a new in_valid is not consumed.
REQ-034 Reset pulsed low during SCAN of 16'h0400 -> out_valid never asserts for that value; in_ready = 1 after release; a subsequent 16'h0002 gives out_state 1 at accept+2.
REQ-035 Sweep 2^1..2^14 back-to-back with out_ready = 1 -> out_state equals k each time, with no lost or duplicated results.
